// File: rtl/muldiv_ctrl.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32-step shift-add multiply,
// 32-step restoring divide, sign fixup, and MTHI/MTLO writes while idle.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_DIV   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state, w_next;
  logic [5:0]           r_cnt;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic [WIDTH-1:0]     r_p_hi, r_p_lo, r_mcand;
  logic                 r_is_div, r_sign_q, r_sign_r;
  logic                 r_busy, r_done, r_div_zero;
  logic                 w_zero;

  logic [WIDTH-1:0]     w_a_mag, w_b_mag, w_addend, w_diff;
  logic [WIDTH:0]       w_sum, w_shift;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_prod, w_prod_fix;

  // Signed ops (op[0]=1) work on magnitudes; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude.
  assign w_a_mag  = (op[0] && a[WIDTH-1]) ? -a : a;
  assign w_b_mag  = (op[0] && b[WIDTH-1]) ? -b : b;

  // r_p_hi:r_p_lo is the product shift register (multiply) or remainder:quotient
  // register (divide); r_p_lo starts as the multiplier/dividend in both cases.
  assign w_addend = r_p_lo[0] ? r_mcand : '0;
  assign w_sum    = {1'b0, r_p_hi} + {1'b0, w_addend};
  assign w_shift  = {r_p_hi, r_p_lo[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, r_mcand});
  assign w_diff   = w_shift[WIDTH-1:0] - r_mcand;
  assign w_prod     = {r_p_hi, r_p_lo};
  assign w_prod_fix = r_sign_q ? -w_prod : w_prod;

  always_comb begin
    w_next = r_state;
    w_zero = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op[1] && (b == '0)) begin
            w_next = S_DONE;
            w_zero = 1'b1;
          end else begin
            w_next = op[1] ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL, S_DIV: if (r_cnt == 6'd1) w_next = S_FIXUP;
      S_FIXUP:      w_next = S_DONE;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 6'd0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_p_hi     <= '0;
      r_p_lo     <= '0;
      r_mcand    <= '0;
      r_is_div   <= 1'b0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next == S_MUL) || (w_next == S_DIV) || (w_next == S_FIXUP);
      r_done     <= (w_next == S_DONE);
      r_div_zero <= w_zero;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt    <= 6'd32;
            r_p_hi   <= '0;
            r_p_lo   <= w_a_mag;
            r_mcand  <= w_b_mag;
            r_is_div <= op[1];
            r_sign_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_sign_r <= op[0] & a[WIDTH-1];
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_MUL: begin
          r_p_hi <= w_sum[WIDTH:1];
          r_p_lo <= {w_sum[0], r_p_lo[WIDTH-1:1]};
          r_cnt  <= r_cnt - 6'd1;
        end
        S_DIV: begin
          r_p_hi <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_p_lo <= {r_p_lo[WIDTH-2:0], w_ge};
          r_cnt  <= r_cnt - 6'd1;
        end
        S_FIXUP: begin
          if (r_is_div) begin
            r_lo <= r_sign_q ? -r_p_lo : r_p_lo;
            r_hi <= r_sign_r ? -r_p_hi : r_p_hi;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign busy      = r_busy;
  assign done      = r_done;
  assign div_zero  = r_div_zero;
  assign dbg_state = r_state;

endmodule
